// File: rtl/arch_pkg.sv
// ---------------------------------------------------------------------------
// arch_pkg
// Shared definitions for the 32-bit datapath: default widths, ALU opcode
// encodings, the zero-register index and the packed control-bit bundle
// carried down the pipeline.
// ---------------------------------------------------------------------------
package arch_pkg;

   localparam int DEF_XLEN = 32;
   localparam int DEF_RW   = 5;

   // ALU opcodes presented on SEL
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_SLT   = 3'd4;
   localparam logic [2:0] ALU_MUL   = 3'd5;
   localparam logic [2:0] ALU_DIV   = 3'd6;
   localparam logic [2:0] ALU_PASSB = 3'd7;

   // Architectural zero register: never a forwarding or hazard target
   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Operand forwarding for one source register. Picks the youngest in-flight
// producer of idx_i (EX/MEM before MEM/WB); falls back to the value read
// from the register file at decode.
//   idx_i        : source register index held in ID/EX
//   reg_data_i   : register-file data held in ID/EX
//   exmem_*_i    : EX/MEM producer (write enable, destination, result)
//   memwb_*_i    : MEM/WB producer (write enable, destination, result)
//   data_o       : forwarded operand
// ---------------------------------------------------------------------------
module fwd_mux
   import arch_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int RW   = DEF_RW
) (
   input  logic [RW-1:0]   idx_i,
   input  logic [XLEN-1:0] reg_data_i,
   input  logic            exmem_reg_write_i,
   input  logic [RW-1:0]   exmem_rd_i,
   input  logic [XLEN-1:0] exmem_result_i,
   input  logic            memwb_reg_write_i,
   input  logic [RW-1:0]   memwb_rd_i,
   input  logic [XLEN-1:0] memwb_result_i,
   output logic [XLEN-1:0] data_o
);

   logic idx_nz;
   logic exmem_hit;
   logic memwb_hit;

   // r0 reads as zero architecturally, so a write "to r0" must not leak
   assign idx_nz    = (idx_i != RW'(REG_ZERO));
   assign exmem_hit = exmem_reg_write_i & (exmem_rd_i == idx_i) & idx_nz;
   assign memwb_hit = memwb_reg_write_i & (memwb_rd_i == idx_i) & idx_nz;

   always_comb begin
      data_o = reg_data_i;
      if (exmem_hit)      data_o = exmem_result_i;
      else if (memwb_hit) data_o = memwb_result_i;
   end

endmodule

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// Decode-to-execute pipeline register. Captures the decoded instruction,
// forwards its operands onto A/B for the ALU, detects load-use hazards and
// inserts bubbles on load-use or flush; stall holds the contents.
//   clk, rst          : clock, asynchronous active-high reset
//   stall, flush      : hold contents / load a bubble (flush wins)
//   in_*              : decoded instruction from the ID stage
//   exmem_*, memwb_*  : forwarding sources
//   A, B, SEL         : ALU operands and opcode
//   ex_*              : registered instruction fields for later stages
//   load_use          : upstream stages must hold this cycle
// ---------------------------------------------------------------------------
module id_ex_reg
   import arch_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int RW   = DEF_RW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [RW-1:0]   in_rs,
   input  logic [RW-1:0]   in_rt,
   input  logic [RW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_rs_data,
   input  logic [XLEN-1:0] in_rt_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [2:0]      in_sel,
   input  logic            in_alu_src,
   input  logic            in_reg_write,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic            in_mem_to_reg,
   input  logic            exmem_reg_write,
   input  logic [RW-1:0]   exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [RW-1:0]   memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] A,
   output logic [XLEN-1:0] B,
   output logic [2:0]      SEL,
   output logic            ex_valid,
   output logic [RW-1:0]   ex_rd,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic            load_use
);

   // ------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------
   logic            valid_q,   valid_d;
   logic [RW-1:0]   rs_q,      rs_d;
   logic [RW-1:0]   rt_q,      rt_d;
   logic [RW-1:0]   rd_q,      rd_d;
   logic [XLEN-1:0] rs_data_q, rs_data_d;
   logic [XLEN-1:0] rt_data_q, rt_data_d;
   logic [XLEN-1:0] imm_q,     imm_d;
   logic [2:0]      sel_q,     sel_d;
   logic            alu_src_q, alu_src_d;
   ctrl_t           ctrl_q,    ctrl_d;

   ctrl_t           in_ctrl;
   logic [XLEN-1:0] rs_fwd;
   logic [XLEN-1:0] rt_fwd;

   assign in_ctrl = '{reg_write:  in_reg_write,
                      mem_read:   in_mem_read,
                      mem_write:  in_mem_write,
                      mem_to_reg: in_mem_to_reg};

   // ------------------------------------------------------------------
   // Load-use hazard: the load in EX cannot forward its data in time to
   // the instruction in decode. Deliberately unmasked by stall/flush so
   // the upstream hold stays asserted while we are stalled.
   // ------------------------------------------------------------------
   assign load_use = valid_q & ctrl_q.mem_read & (rd_q != RW'(REG_ZERO)) &
                     in_valid & ((in_rs == rd_q) | (in_rt == rd_q));

   // ------------------------------------------------------------------
   // Next state: flush > stall > load_use bubble > load
   // ------------------------------------------------------------------
   always_comb begin
      valid_d   = valid_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      sel_d     = sel_q;
      alu_src_d = alu_src_q;
      ctrl_d    = ctrl_q;

      if (flush || (!stall && load_use)) begin
         // bubble: all-zero fields, so no register or memory side effects
         valid_d   = 1'b0;
         rs_d      = '0;
         rt_d      = '0;
         rd_d      = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
         sel_d     = ALU_ADD;
         alu_src_d = 1'b0;
         ctrl_d    = CTRL_NOP;
      end else if (!stall) begin
         valid_d   = in_valid;
         rs_d      = in_rs;
         rt_d      = in_rt;
         rd_d      = in_rd;
         rs_data_d = in_rs_data;
         rt_data_d = in_rt_data;
         imm_d     = in_imm;
         sel_d     = in_sel;
         alu_src_d = in_alu_src;
         ctrl_d    = in_ctrl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         sel_q     <= ALU_ADD;
         alu_src_q <= 1'b0;
         ctrl_q    <= CTRL_NOP;
      end else begin
         valid_q   <= valid_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         sel_q     <= sel_d;
         alu_src_q <= alu_src_d;
         ctrl_q    <= ctrl_d;
      end
   end

   // ------------------------------------------------------------------
   // Operand forwarding (combinational from the registered indices)
   // ------------------------------------------------------------------
   fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs (
      .idx_i             (rs_q),
      .reg_data_i        (rs_data_q),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .exmem_result_i    (exmem_result),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_result_i    (memwb_result),
      .data_o            (rs_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rt (
      .idx_i             (rt_q),
      .reg_data_i        (rt_data_q),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .exmem_result_i    (exmem_result),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_result_i    (memwb_result),
      .data_o            (rt_fwd)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign A             = rs_fwd;
   assign B             = alu_src_q ? imm_q : rt_fwd;
   // stores always need the rt value, even when B carries the immediate
   assign ex_store_data = rt_fwd;
   assign SEL           = sel_q;
   assign ex_valid      = valid_q;
   assign ex_rd         = rd_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
// Self-checking bench for id_ex_reg: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            stall, flush, in_valid;
   logic [RW-1:0]   in_rs, in_rt, in_rd;
   logic [XLEN-1:0] in_rs_data, in_rt_data, in_imm;
   logic [2:0]      in_sel;
   logic            in_alu_src, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
   logic            exmem_reg_write, memwb_reg_write;
   logic [RW-1:0]   exmem_rd, memwb_rd;
   logic [XLEN-1:0] exmem_result, memwb_result;
   logic [XLEN-1:0] A, B, ex_store_data;
   logic [2:0]      SEL;
   logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use;
   logic [RW-1:0]   ex_rd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.XLEN(XLEN), .RW(RW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_sel(in_sel), .in_alu_src(in_alu_src),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .A(A), .B(B), .SEL(SEL), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .load_use(load_use)
   );

   // ------------------------------------------------------------------
   // Behavioural model: the stage is just "the instruction currently in EX"
   // ------------------------------------------------------------------
   typedef struct packed {
      logic            valid;
      logic [RW-1:0]   rs, rt, rd;
      logic [XLEN-1:0] rs_data, rt_data, imm;
      logic [2:0]      sel;
      logic            alu_src, rw, mr, mw, m2r;
   } instr_t;

   instr_t m = '0;

   function automatic instr_t decode_slot();
      instr_t t;
      t = '{valid: in_valid, rs: in_rs, rt: in_rt, rd: in_rd,
            rs_data: in_rs_data, rt_data: in_rt_data, imm: in_imm,
            sel: in_sel, alu_src: in_alu_src, rw: in_reg_write,
            mr: in_mem_read, mw: in_mem_write, m2r: in_mem_to_reg};
      return t;
   endfunction

   // decode instruction reads a register the load in EX has not produced yet
   function automatic logic hazard();
      return m.valid && m.mr && m.rd != 0 && in_valid &&
             (in_rs == m.rd || in_rt == m.rd);
   endfunction

   // value a reader of register idx must see, youngest producer first
   function automatic logic [XLEN-1:0] operand(input logic [RW-1:0] idx,
                                               input logic [XLEN-1:0] rf);
      if (idx == 0)                                  return rf;
      if (exmem_reg_write && exmem_rd == idx)        return exmem_result;
      if (memwb_reg_write && memwb_rd == idx)        return memwb_result;
      return rf;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst)                    m <= '0;
      else if (flush)             m <= '0;
      else if (stall)             m <= m;
      else if (hazard())          m <= '0;
      else                        m <= decode_slot();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // one compare per cycle, away from the active edge
   always @(negedge clk) begin
      chk("m_A",        A,                    operand(m.rs, m.rs_data));
      chk("m_B",        B,                    m.alu_src ? m.imm : operand(m.rt, m.rt_data));
      chk("m_store",    ex_store_data,        operand(m.rt, m.rt_data));
      chk("m_SEL",      32'(SEL),             32'(m.sel));
      chk("m_valid",    32'(ex_valid),        32'(m.valid));
      chk("m_rd",       32'(ex_rd),           32'(m.rd));
      chk("m_ctrl",     32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                        32'({m.rw, m.mr, m.mw, m.m2r}));
      chk("m_load_use", 32'(load_use),        32'(hazard()));
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      stall = 0; flush = 0; in_valid = 0;
      in_rs = 0; in_rt = 0; in_rd = 0;
      in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_sel = 0;
      in_alu_src = 0; in_reg_write = 0; in_mem_read = 0;
      in_mem_write = 0; in_mem_to_reg = 0;
   endtask

   task automatic clr_fwd();
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic rand_in(input bit with_fwd);
      in_valid      = 1'($urandom_range(0, 1));
      in_rs         = 5'($urandom_range(0, 7));
      in_rt         = 5'($urandom_range(0, 7));
      in_rd         = 5'($urandom_range(0, 7));
      in_rs_data    = $urandom;
      in_rt_data    = $urandom;
      in_imm        = $urandom;
      in_sel        = 3'($urandom_range(0, 7));
      in_alu_src    = 1'($urandom_range(0, 1));
      in_reg_write  = 1'($urandom_range(0, 1));
      in_mem_read   = 1'($urandom_range(0, 2) == 0);
      in_mem_write  = 1'($urandom_range(0, 1));
      in_mem_to_reg = 1'($urandom_range(0, 1));
      if (with_fwd) begin
         exmem_reg_write = 1'($urandom_range(0, 1));
         exmem_rd        = 5'($urandom_range(0, 7));
         exmem_result    = $urandom;
         memwb_reg_write = 1'($urandom_range(0, 1));
         memwb_rd        = 5'($urandom_range(0, 7));
         memwb_result    = $urandom;
      end
   endtask

   initial begin
      clr_in();
      clr_fwd();
      repeat (2) @(posedge clk);
      #1;
      // reset state: r0 producers must not reach A/B
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD_BEEF;
      memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hCAFE_F00D;
      #1;
      chk("rst_valid",    32'(ex_valid), 0);
      chk("rst_SEL",      32'(SEL), 0);
      chk("rst_rd",       32'(ex_rd), 0);
      chk("rst_A",        A, 0);
      chk("rst_B",        B, 0);
      chk("rst_ctrl",     32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 0);
      chk("rst_load_use", 32'(load_use), 0);
      clr_fwd();
      rst = 0;

      // basic load
      in_valid = 1; in_rs = 3; in_rs_data = 10; in_rt = 4; in_rt_data = 20;
      in_sel = 0; in_rd = 8; in_reg_write = 1;
      step();
      chk("ld_A",     A, 10);
      chk("ld_B",     B, 20);
      chk("ld_SEL",   32'(SEL), 0);
      chk("ld_valid", 32'(ex_valid), 1);

      // forwarding priority, stage held
      stall = 1;
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 7;
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 9;
      #1 chk("fwd_exmem", A, 7);
      chk("fwd_B_untouched", B, 20);
      exmem_reg_write = 0;
      #1 chk("fwd_memwb", A, 9);
      clr_fwd();
      stall = 0;
      in_rs = 0; in_rs_data = 32'h123;
      step();
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 7;
      memwb_reg_write = 1; memwb_rd = 0; memwb_result = 9;
      #1 chk("fwd_r0", A, 32'h123);
      clr_fwd();

      // load-use hazard
      clr_in();
      in_valid = 1; in_rs = 1; in_rt = 2; in_rd = 5;
      in_mem_read = 1; in_reg_write = 1; in_mem_to_reg = 1;
      step();
      in_rs = 5; in_rt = 6; in_rd = 7; in_mem_read = 0; in_mem_to_reg = 0;
      #1 chk("lu_detect", 32'(load_use), 1);
      step();
      chk("lu_bubble_valid", 32'(ex_valid), 0);
      chk("lu_bubble_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 0);
      chk("lu_clear",        32'(load_use), 0);
      step();
      chk("lu_issue_valid", 32'(ex_valid), 1);
      chk("lu_issue_rd",    32'(ex_rd), 7);

      // immediate on B, store data keeps forwarded rt
      clr_in();
      in_valid = 1; in_rs = 2; in_rs_data = 32'h22; in_rt = 4; in_rt_data = 32'h11;
      in_alu_src = 1; in_imm = 32'hFFFF_FFFC; in_sel = 5; in_rd = 9; in_mem_write = 1;
      step();
      exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h55;
      #1;
      chk("imm_B",     B, 32'hFFFF_FFFC);
      chk("imm_store", ex_store_data, 32'h55);
      chk("imm_A",     A, 32'h22);
      clr_fwd();

      // stall holds while decode changes
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rand_in(1'b0);
         step();
         chk("stall_A",     A, 32'h22);
         chk("stall_B",     B, 32'hFFFF_FFFC);
         chk("stall_SEL",   32'(SEL), 5);
         chk("stall_rd",    32'(ex_rd), 9);
         chk("stall_store", ex_store_data, 32'h11);
      end
      flush = 1;
      step();
      chk("flush_valid", 32'(ex_valid), 0);
      chk("flush_SEL",   32'(SEL), 0);
      chk("flush_A",     A, 0);
      chk("flush_rd",    32'(ex_rd), 0);
      chk("flush_mw",    32'(ex_mem_write), 0);

      // asynchronous reset between edges
      clr_in();
      in_valid = 1; in_reg_write = 1; in_rd = 3; in_rs = 1; in_rs_data = 32'h77;
      step();
      chk("pre_arst_valid", 32'(ex_valid), 1);
      chk("pre_arst_rw",    32'(ex_reg_write), 1);
      #1 rst = 1;
      #1;
      chk("arst_valid", 32'(ex_valid), 0);
      chk("arst_rw",    32'(ex_reg_write), 0);
      chk("arst_A",     A, 0);
      chk("arst_rd",    32'(ex_rd), 0);
      #1 rst = 0;

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         step();
         rand_in(1'b1);
         stall = 1'($urandom_range(0, 9) == 0);
         flush = 1'($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #1 rst = 1;
            #1 rst = 0;
         end
      end

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
